// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that drains a synchronous FIFO with one-cycle read latency.
// Every output is driven by a flop; nothing passes combinationally from input to output.
module fifo_uart_tx #(
  parameter int DW           = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_re,
  output logic          tx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

  state_t        state;
  logic [DW-1:0] sh;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          wrap;

  assign wrap = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sh      <= '0;
      cnt     <= '0;
      idx     <= '0;
      fifo_re <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (en && !fifo_empty) begin
            state   <= FETCH;
            fifo_re <= 1'b1;
            busy    <= 1'b1;
          end
        end
        FETCH: begin
          fifo_re <= 1'b0;
          state   <= LOAD;
        end
        // The FIFO presents the popped byte during this cycle.
        LOAD: begin
          sh    <= fifo_dout;
          cnt   <= '0;
          tx    <= 1'b0;
          state <= START;
        end
        START: begin
          if (wrap) begin
            cnt   <= '0;
            idx   <= '0;
            tx    <= sh[0];
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (wrap) begin
            cnt <= '0;
            if (idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
              tx  <= sh[idx + 3'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (wrap) begin
            cnt   <= '0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          fifo_re <= 1'b0;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural 16x8 FIFO on the read side, a UART receiver on tx,
// and a byte scoreboard filled at write time and drained as frames are decoded.
module tb_fifo_uart_tx;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_re, tx, busy, done;
  logic       wr = 1'b0;
  logic [7:0] wdata = 8'h00;

  int errors = 0, checks = 0, cyc = 0, underflow = 0;
  logic [7:0] fq[$], exp_q[$], rx_q[$];
  int starts[$];
  int re_pulses = 0, re_cycles = 0, done_pulses = 0, done_cycles = 0;
  int last_re_cyc = 0, last_done_cyc = 0, frame_err = 0, mon_pos = 0;
  logic mon_st = 1'b0, bitval = 1'b1, re_prev = 1'b0, done_prev = 1'b0;
  logic [7:0] shreg = 8'h00;

  fifo_uart_tx #(.DW(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_re(fifo_re), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 16-deep FIFO with registered read data and registered empty flag.
  always @(posedge clk) begin
    if (wr && fq.size() < 16) fq.push_back(wdata);
    if (fifo_re) begin
      if (fq.size() == 0) underflow <= underflow + 1;
      else fifo_dout <= fq.pop_front();
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Receiver: tx only moves on posedge, so each bit spans exactly CPB negedges.
  initial forever begin
    @(negedge clk);
    if (fifo_re) re_cycles++;
    if (fifo_re && !re_prev) begin re_pulses++; last_re_cyc = cyc; end
    re_prev = fifo_re;
    if (done) done_cycles++;
    if (done && !done_prev) begin done_pulses++; last_done_cyc = cyc; end
    done_prev = done;
    if (!rst) mon_st = 1'b0;
    else if (!mon_st) begin
      if (tx === 1'b0) begin
        mon_st = 1'b1; mon_pos = 0; bitval = 1'b0; starts.push_back(cyc);
      end
    end else begin
      mon_pos++;
      if (mon_pos % CPB == 0) bitval = tx;
      else if (tx !== bitval) frame_err++;
      if (mon_pos % CPB == CPB / 2) begin
        if (mon_pos / CPB == 0 && tx !== 1'b0) frame_err++;
        else if (mon_pos / CPB >= 1 && mon_pos / CPB <= 8) shreg[mon_pos / CPB - 1] = tx;
        else if (mon_pos / CPB == 9 && tx !== 1'b1) frame_err++;
      end
      if (mon_pos == FRAME - 1) begin rx_q.push_back(shreg); mon_st = 1'b0; end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk); wr = 1'b1; wdata = b; exp_q.push_back(b);
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 checks++;
    if ({tx, busy, fifo_re, done} !== 4'b1000) begin
      errors++; $display("FAIL reset_outputs got {tx,busy,re,done}=%b want 1000", {tx, busy, fifo_re, done});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_idle();
    int viol = 0;
    en = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if ({tx, fifo_re, busy} !== 3'b100) viol++;
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL idle_quiet got %0d bad cycles want 0", viol); end
  endtask

  task automatic test_single();
    int r0 = re_pulses, rc0 = re_cycles, d0 = done_pulses, dc0 = done_cycles, s0 = starts.size();
    logic [7:0] got, want;
    push_byte(8'hA5);
    for (int i = 0; i < 200 && rx_q.size() < 1; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q.size() != 1) begin errors++; $display("FAIL single_rx_count got %0d want 1", rx_q.size()); end
    else begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL single_byte got %h want %h", got, want); end
      checks++;
      if (starts[s0] - last_re_cyc != 2) begin
        errors++; $display("FAIL single_re_to_start got %0d want 2", starts[s0] - last_re_cyc);
      end
      checks++;
      if (last_done_cyc != starts[s0] + FRAME) begin
        errors++; $display("FAIL single_done_time got %0d want %0d", last_done_cyc, starts[s0] + FRAME);
      end
    end
    checks++;
    if (re_pulses - r0 != 1 || re_cycles - rc0 != 1) begin
      errors++; $display("FAIL single_re got pulses=%0d cycles=%0d want 1/1", re_pulses - r0, re_cycles - rc0);
    end
    checks++;
    if (done_pulses - d0 != 1 || done_cycles - dc0 != 1) begin
      errors++; $display("FAIL single_done got pulses=%0d cycles=%0d want 1/1", done_pulses - d0, done_cycles - dc0);
    end
    checks++;
    if (busy !== 1'b0 || frame_err != 0) begin
      errors++; $display("FAIL single_end got busy=%b frame_err=%0d want 0/0", busy, frame_err);
    end
  endtask

  task automatic test_back_to_back();
    int r0 = re_pulses, s0 = starts.size();
    logic [7:0] got, want;
    push_byte(8'h00);
    push_byte(8'hFF);
    for (int i = 0; i < 400 && rx_q.size() < 2; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q.size() != 2) begin errors++; $display("FAIL b2b_rx_count got %0d want 2", rx_q.size()); end
    else begin
      for (int k = 0; k < 2; k++) begin
        got = rx_q.pop_front(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", k, got, want); end
      end
      checks++;
      if (starts[s0 + 1] - starts[s0] - FRAME != 3) begin
        errors++; $display("FAIL b2b_gap got %0d want 3", starts[s0 + 1] - starts[s0] - FRAME);
      end
    end
    checks++;
    if (re_pulses - r0 != 2 || fifo_empty !== 1'b1) begin
      errors++; $display("FAIL b2b_re_empty got re=%0d empty=%b want 2/1", re_pulses - r0, fifo_empty);
    end
  endtask

  task automatic test_burst();
    int d0 = done_pulses, s0 = starts.size(), bad = 0, badgap = 0;
    logic [7:0] got, want;
    en = 1'b0;
    for (int k = 1; k <= 16; k++) push_byte(8'(k));
    repeat (3) @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 1200 && rx_q.size() < 16; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q.size() != 16) begin errors++; $display("FAIL burst_rx_count got %0d want 16", rx_q.size()); end
    else begin
      for (int k = 0; k < 16; k++) begin
        got = rx_q.pop_front(); want = exp_q.pop_front();
        if (got !== want) bad++;
        if (k > 0 && starts[s0 + k] - starts[s0 + k - 1] - FRAME != 3) badgap++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL burst_bytes got %0d wrong want 0", bad); end
      checks++;
      if (badgap != 0) begin errors++; $display("FAIL burst_gaps got %0d wrong want 0", badgap); end
    end
    checks++;
    if (done_pulses - d0 != 16) begin errors++; $display("FAIL burst_done got %0d want 16", done_pulses - d0); end
    checks++;
    if (fifo_empty !== 1'b1 || underflow != 0 || frame_err != 0) begin
      errors++; $display("FAIL burst_end got empty=%b underflow=%0d frame_err=%0d want 1/0/0",
                         fifo_empty, underflow, frame_err);
    end
  endtask

  task automatic test_mid_reset();
    int s0, d0, viol = 0, i;
    logic [7:0] dropped;
    push_byte(8'h3C);
    for (i = 0; i < 200 && !(mon_st && mon_pos >= 17); i++) @(negedge clk);
    checks++;
    if (!(mon_st && mon_pos >= 17)) begin errors++; $display("FAIL mid_reset_reach got pos=%0d want >=17", mon_pos); end
    #2 rst = 1'b0;
    #1 checks++;
    if ({tx, busy, fifo_re, done} !== 4'b1000) begin
      errors++; $display("FAIL mid_reset_async got {tx,busy,re,done}=%b want 1000", {tx, busy, fifo_re, done});
    end
    dropped = exp_q.pop_front();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    s0 = starts.size(); d0 = done_pulses;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) viol++;
    end
    checks++;
    if (viol != 0 || starts.size() != s0 || rx_q.size() != 0 || done_pulses != d0) begin
      errors++; $display("FAIL mid_reset_after got low=%0d starts=%0d rx=%0d done=%0d want 0/0/0/0 (byte %h)",
                         viol, starts.size() - s0, rx_q.size(), done_pulses - d0, dropped);
    end
  endtask

  task automatic test_en_gating();
    int s0 = starts.size(), r0 = re_pulses, c;
    logic [7:0] got, want;
    en = 1'b1;
    push_byte(8'h55);
    push_byte(8'h66);
    for (int i = 0; i < 100 && starts.size() <= s0; i++) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 200 && rx_q.size() < 1; i++) @(negedge clk);
    repeat (60) @(negedge clk);
    checks++;
    if (starts.size() != s0 + 1 || re_pulses - r0 != 1 || fifo_empty !== 1'b0) begin
      errors++; $display("FAIL en_hold got frames=%0d re=%0d empty=%b want 1/1/0",
                         starts.size() - s0, re_pulses - r0, fifo_empty);
    end
    en = 1'b1;
    @(negedge clk);
    c = cyc;
    checks++;
    if (fifo_re !== 1'b1) begin errors++; $display("FAIL en_re_latency got re=%b want 1", fifo_re); end
    for (int i = 0; i < 100 && starts.size() < s0 + 2; i++) @(negedge clk);
    checks++;
    if (starts.size() < s0 + 2) begin errors++; $display("FAIL en_restart got no frame want frame"); end
    else if (starts[s0 + 1] - c != 2) begin
      errors++; $display("FAIL en_restart got re_to_start=%0d want 2", starts[s0 + 1] - c);
    end
    for (int i = 0; i < 200 && rx_q.size() < 2; i++) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rx_q.size() == 0) begin errors++; $display("FAIL en_byte%0d got none want %h", k, exp_q[0]); end
      else begin
        got = rx_q.pop_front(); want = exp_q.pop_front();
        if (got !== want) begin errors++; $display("FAIL en_byte%0d got %h want %h", k, got, want); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_burst();
    test_mid_reset();
    test_en_gating();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout got time=%0t want completion", $time);
    $fatal(1, "timeout");
  end
endmodule
